// File: rtl/wc_seq_pkg.sv
// Shared definitions for the wc tile sequencer: default width, FSM states
// and the legal frame length window.
package wc_seq_pkg;

    localparam int DW_DEF    = 10;
    localparam int FRAME_MIN = 4;
    localparam int FRAME_MAX = 254;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_DRAIN
    } state_e;

    // A frame must hold an even number of samples inside the legal window.
    function automatic logic frame_len_ok(input logic [7:0] n);
        return (n[0] == 1'b0) && (n >= 8'(FRAME_MIN)) && (n <= 8'(FRAME_MAX));
    endfunction

endpackage

// File: rtl/wc.sv
// Fixed-kernel wc datapath: two 3-tap outputs per 4-sample tile, with a
// WC_LAT-deep register pipeline between wc_d_i and wc_z_o.
module wc import wc_seq_pkg::*; #(
    parameter int DW     = DW_DEF,
    parameter int WC_LAT = 6,
    parameter int G0     = 4,
    parameter int G1     = 1,
    parameter int G2     = 13
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [4*DW-1:0] wc_d_i,
    output logic [2*DW-1:0] wc_z_o
);

    logic signed [DW-1:0] x0, x1, x2, x3;
    logic        [DW-1:0] y0, y1;
    logic      [2*DW-1:0] z_q [WC_LAT];

    assign {x0, x1, x2, x3} = wc_d_i;

    // Results wrap to DW bits, matching the sample width.
    assign y0 = DW'(G0 * 32'(x0) + G1 * 32'(x1) + G2 * 32'(x2));
    assign y1 = DW'(G0 * 32'(x1) + G1 * 32'(x2) + G2 * 32'(x3));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WC_LAT; i++) begin
                z_q[i] <= '0;
            end
        end else begin
            z_q[0] <= {y0, y1};
            for (int i = 1; i < WC_LAT; i++) begin
                z_q[i] <= z_q[i-1];
            end
        end
    end

    assign wc_z_o = z_q[WC_LAT-1];

endmodule

// File: rtl/wc_ofifo.sv
// Synchronous FIFO for wc results; head is visible combinationally so the
// result stream can present it as soon as the FIFO is non-empty.
module wc_ofifo #(
    parameter int W     = 21,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_wr, do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_rd = rd_en_i && (count_q != '0);
    // A write into a full FIFO is accepted only when a read frees a slot.
    assign do_wr = wr_en_i && ((count_q != CW'(DEPTH)) || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/wc_seq.sv
// Frame sequencer: slides a 4-sample window by 2 over each frame, issues
// tiles to the external wc datapath and streams the results with credit flow.
module wc_seq import wc_seq_pkg::*; #(
    parameter int DW       = DW_DEF,
    parameter int WC_LAT   = 6,
    parameter int OF_DEPTH = 8
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      frame_len,
    output logic            busy,
    output logic            err,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    output logic [4*DW-1:0] wc_d,
    input  logic [2*DW-1:0] wc_z,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [2*DW-1:0] m_data,
    output logic            m_last
);

    localparam int CW = $clog2(OF_DEPTH + 1);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [6:0]        tiles_q, tiles_d;
    logic [DW-1:0]     win_q [4];
    logic [4*DW-1:0]   win_flat, wc_d_q;
    logic              err_q, iss_vld_q, iss_last_q;
    logic [WC_LAT-1:0] vld_q, lst_q;
    logic [CW-1:0]     inflight_q, fifo_count;
    logic [CW:0]       occ;
    logic              fifo_empty;
    logic [2*DW:0]     fifo_head;
    logic              take, issue, occ_ok, start_ok, start_bad;
    logic              fifo_wr, fifo_rd, last_beat;

    for (genvar gi = 0; gi < 4; gi++) begin : g_win
        assign win_flat[(3-gi)*DW +: DW] = win_q[gi];
    end

    // Results still in the wc pipe already own a FIFO slot.
    assign occ       = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign occ_ok    = occ < (CW+1)'(OF_DEPTH);
    assign s_ready   = (state_q == ST_FILL);
    assign take      = s_ready && s_valid;
    assign issue     = (state_q == ST_ISSUE) && occ_ok;
    assign start_ok  = (state_q == ST_IDLE) && start && frame_len_ok(frame_len);
    assign start_bad = (state_q == ST_IDLE) && start && !frame_len_ok(frame_len);
    assign fifo_wr   = vld_q[WC_LAT-1];
    assign fifo_rd   = m_valid && m_ready;
    assign last_beat = fifo_rd && m_last;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tiles_d = tiles_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_FILL;
                    idx_d   = 2'd0;
                    tiles_d = frame_len[7:1] - 7'd1;
                end
            end
            ST_FILL: begin
                if (take) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    idx_d   = 2'd2;
                    tiles_d = tiles_q - 7'd1;
                    state_d = (tiles_q == 7'd1) ? ST_DRAIN : ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tiles_q    <= '0;
            err_q      <= 1'b0;
            wc_d_q     <= '0;
            iss_vld_q  <= 1'b0;
            iss_last_q <= 1'b0;
            vld_q      <= '0;
            lst_q      <= '0;
            inflight_q <= '0;
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tiles_q    <= tiles_d;
            err_q      <= start_bad;
            iss_vld_q  <= issue;
            iss_last_q <= issue && (tiles_q == 7'd1);
            // The pipe starts one cycle after issue, when wc_d holds the tile.
            vld_q[0]   <= iss_vld_q;
            lst_q[0]   <= iss_last_q;
            for (int i = 1; i < WC_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
            if (take) begin
                win_q[idx_q] <= s_data;
            end
            if (issue) begin
                wc_d_q   <= win_flat;
                win_q[0] <= win_q[2];
                win_q[1] <= win_q[3];
            end
            case ({issue, fifo_wr})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    wc_ofifo #(
        .W     (2*DW + 1),
        .DEPTH (OF_DEPTH),
        .CW    (CW)
    ) u_ofifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i ({lst_q[WC_LAT-1], wc_z}),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;
    assign wc_d    = wc_d_q;
    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : fifo_head[2*DW-1:0];
    assign m_last  = !fifo_empty && fifo_head[2*DW];

endmodule

// File: tb/tb_wc_seq.sv
// Bench for wc_seq + wc datapath: directed frames, rejected starts, stall,
// mid-frame reset and randomized frames against a queue-based result model.
module tb_wc_seq;

    localparam int DW       = 10;
    localparam int WC_LAT   = 6;
    localparam int OF_DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst, start;
    logic [7:0]      frame_len;
    logic            busy, err;
    logic            s_valid, s_ready;
    logic [DW-1:0]   s_data;
    logic [4*DW-1:0] wc_d;
    logic [2*DW-1:0] wc_z;
    logic            m_valid, m_ready, m_last;
    logic [2*DW-1:0] m_data;

    always #5 clk = ~clk;

    wc_seq #(.DW(DW), .WC_LAT(WC_LAT), .OF_DEPTH(OF_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .busy(busy), .err(err), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .wc_d(wc_d), .wc_z(wc_z), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    wc #(.DW(DW), .WC_LAT(WC_LAT)) u_wc (
        .clk(clk), .rst(rst), .wc_d_i(wc_d), .wc_z_o(wc_z)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            frame_smp[$];
    int            src_q[$];
    logic [2*DW:0] exp_q[$];
    int            valid_mode = 0;
    int            ready_mode = 0;
    bit            tgl = 1'b0;
    int            beats, err_pulses, consumed, sready_seen, mvalid_seen;
    bit            last_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] to_dw(input int v);
        return v[DW-1:0];
    endfunction

    function automatic logic [4*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {to_dw(a), to_dw(b), to_dw(c), to_dw(d)};
    endfunction

    // Reference: tile t covers samples 2t..2t+3, kernel g=(4,1,13).
    function automatic void model_frame(input int n);
        int a0, a1, a2, a3, y0, y1;
        for (int t = 0; t < n/2 - 1; t++) begin
            a0 = frame_smp[2*t];
            a1 = frame_smp[2*t+1];
            a2 = frame_smp[2*t+2];
            a3 = frame_smp[2*t+3];
            y0 = 4*a0 + a1 + 13*a2;
            y1 = 4*a1 + a2 + 13*a3;
            exp_q.push_back({(t == n/2 - 2), to_dw(y0), to_dw(y1)});
        end
    endfunction

    task automatic drive();
        bit have;
        have = (src_q.size() != 0);
        case (valid_mode)
            0: s_valid = have;
            1: begin tgl = ~tgl; s_valid = have && tgl; end
            default: s_valid = have && ($urandom_range(0, 1) == 1);
        endcase
        s_data = have ? to_dw(src_q[0]) : to_dw(int'($urandom));
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'b0;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic step();
        bit            took;
        logic [2*DW:0] e;
        @(negedge clk);
        took = s_valid && s_ready;
        if (err) err_pulses++;
        if (s_ready) sready_seen++;
        if (m_valid) mvalid_seen++;
        check("s_ready_only_busy", s_ready & ~busy, 0);
        if (m_valid && m_ready) begin
            beats++;
            $display("beat %0d data=0x%0h last=%0d", beats, m_data, m_last);
            check("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("m_data", m_data, e[2*DW-1:0]);
                check("m_last", m_last, e[2*DW]);
            end
            if (m_last) begin
                check("busy_at_last", busy, 1);
                last_seen = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (took) begin
            void'(src_q.pop_front());
            consumed++;
        end
        drive();
    endtask

    task automatic reset_counts();
        beats = 0; err_pulses = 0; consumed = 0;
        sready_seen = 0; mvalid_seen = 0; last_seen = 1'b0;
    endtask

    task automatic run_frame(input int n, input int vmode, input int rmode,
                             input int stall, input bit bad_mid);
        reset_counts();
        src_q = frame_smp;
        exp_q.delete();
        model_frame(n);
        valid_mode = vmode;
        ready_mode = (stall > 0) ? 1 : rmode;
        start = 1'b1;
        frame_len = 8'(n);
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 5000 && !last_seen; cyc++) begin
            if (stall > 0 && cyc == stall) begin
                check("stall_s_ready", s_ready, 0);
                check("stall_m_valid", m_valid, 1);
                check("stall_consumed", consumed, n);
                check("stall_beats", beats, 0);
                ready_mode = rmode;
            end
            start = bad_mid && (cyc == 2);
            if (start) frame_len = 8'd5;
            step();
        end
        start = 1'b0;
        check("frame_done", last_seen, 1);
        check("beat_count", beats, n/2 - 1);
        check("consumed", consumed, n);
        check("no_err_in_frame", err_pulses, 0);
        check("busy_fall", busy, 0);
        $display("frame n=%0d tiles=%0d beats=%0d", n, n/2 - 1, beats);
    endtask

    task automatic bad_start(input int n);
        reset_counts();
        start = 1'b1;
        frame_len = 8'(n);
        step();
        start = 1'b0;
        check("err_now", err, 1);
        repeat (4) step();
        check("err_pulses", err_pulses, 1);
        check("err_busy", busy, 0);
        check("err_no_s_ready", sready_seen, 0);
        $display("rejected start n=%0d err_pulses=%0d", n, err_pulses);
    endtask

    task automatic rand_samples(input int n);
        frame_smp.delete();
        for (int i = 0; i < n; i++) begin
            frame_smp.push_back(int'($urandom_range(0, 1023)) - 512);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frame_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_wc_d", wc_d, 0);
        rst = 1'b0;
        step();

        frame_smp = '{2, -10, 3, 4};
        run_frame(4, 0, 0, 0, 1'b0);
        frame_smp = '{2, -10, 3, 4, -19, -6};
        run_frame(6, 0, 0, 0, 1'b0);
        frame_smp = '{-19, -6, 3, -9};
        run_frame(4, 1, 0, 0, 1'b0);

        bad_start(5);
        bad_start(2);
        bad_start(255);
        bad_start(0);

        rand_samples(20);
        run_frame(20, 0, 0, 100, 1'b0);

        // Abort a frame after three issues, with results still buffered.
        rand_samples(20);
        reset_counts();
        exp_q.delete();
        src_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(frame_smp[i]);
        valid_mode = 0;
        ready_mode = 1;
        start = 1'b1;
        frame_len = 8'd20;
        step();
        start = 1'b0;
        repeat (20) step();
        check("pre_rst_consumed", consumed, 8);
        check("pre_rst_wc_d", wc_d, pack4(frame_smp[4], frame_smp[5], frame_smp[6], frame_smp[7]));
        rst = 1'b1;
        step();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_s_ready", s_ready, 0);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_last", m_last, 0);
        check("mid_rst_wc_d", wc_d, 0);
        rst = 1'b0;
        src_q.delete();
        reset_counts();
        ready_mode = 0;
        repeat (10) step();
        check("post_rst_m_valid", mvalid_seen, 0);
        frame_smp = '{2, -10, 3, 4};
        run_frame(4, 0, 0, 0, 1'b0);

        rand_samples(254);
        run_frame(254, 0, 2, 0, 1'b0);

        for (int f = 0; f < 25; f++) begin
            int n;
            n = 2 * int'($urandom_range(2, 24));
            if ($urandom_range(0, 3) == 0) bad_start(2 * int'($urandom_range(0, 100)) + 1);
            rand_samples(n);
            run_frame(n, int'($urandom_range(0, 2)), 2 * int'($urandom_range(0, 1)),
                      0, ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
